// File: rtl/data_bus_if.sv
// data_bus_if: data-side bus master behind the memory-access stage.
// Turns a single-cycle RAM-style request into a Wishbone-style cycle,
// holds the pipeline until the slave acks, then returns load data.
// Load data is buffered while other stages keep the pipeline frozen.
// A flush or a slave that never answers aborts the cycle.
module data_bus_if #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE           = 2'd0,
        ST_BUSY           = 2'd1,
        ST_WAIT_FOR_STALL = 2'd2
    } state_t;

    // Everything driven onto the bus; an all-zero value is the idle bus.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } bus_req_t;

    // Counter value seen in the last BUSY cycle allowed before abort.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    bus_req_t    r_bus;
    bus_req_t    w_bus_next;
    logic [31:0] r_rd_buf;
    logic [31:0] w_rd_buf_next;
    logic [15:0] r_tmo_cnt;
    logic [15:0] w_tmo_cnt_next;
    logic        r_bus_err;
    logic        w_bus_err_next;

    logic        w_stallreq;
    logic [31:0] w_cpu_data;
    logic        w_req_ok;
    logic        w_stall_any;
    logic [31:0] w_ack_data;

    assign w_req_ok    = cpu_ce_i & ~flush_i;
    assign w_stall_any = |stall_i;
    // A store returns nothing; a load returns whatever the slave presents.
    assign w_ack_data  = r_bus.we ? 32'h0 : wb_dat_i;

    // Next-state, next-register values and the combinational pipeline-facing outputs.
    always_comb begin
        w_state_next   = r_state;
        w_bus_next     = r_bus;
        w_rd_buf_next  = r_rd_buf;
        w_tmo_cnt_next = r_tmo_cnt;
        w_bus_err_next = 1'b0;
        w_stallreq     = 1'b0;
        w_cpu_data     = 32'h0;

        case (r_state)
            ST_IDLE: begin
                // The request cycle itself already stalls the pipeline.
                w_stallreq = w_req_ok;
                if (w_req_ok) begin
                    w_bus_next.adr = cpu_addr_i;
                    w_bus_next.dat = cpu_data_i;
                    w_bus_next.sel = cpu_sel_i;
                    w_bus_next.we  = cpu_we_i;
                    w_bus_next.cyc = 1'b1;
                    w_bus_next.stb = 1'b1;
                    w_tmo_cnt_next = 16'h0;
                    w_state_next   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (flush_i) begin
                    // Flush wins over ack and timeout: abandon quietly.
                    w_bus_next     = '0;
                    w_rd_buf_next  = 32'h0;
                    w_tmo_cnt_next = 16'h0;
                    w_state_next   = ST_IDLE;
                end else if (wb_ack_i) begin
                    // Data goes straight to the stage in the cycle the stall drops,
                    // and is also kept in case the pipeline stays frozen.
                    w_bus_next     = '0;
                    w_rd_buf_next  = w_ack_data;
                    w_cpu_data     = w_ack_data;
                    w_tmo_cnt_next = 16'h0;
                    w_state_next   = w_stall_any ? ST_WAIT_FOR_STALL : ST_IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    // Slave never answered: release the bus and report once.
                    w_bus_next     = '0;
                    w_rd_buf_next  = 32'h0;
                    w_bus_err_next = 1'b1;
                    w_tmo_cnt_next = 16'h0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_stallreq     = 1'b1;
                    w_tmo_cnt_next = r_tmo_cnt + 16'd1;
                end
            end

            ST_WAIT_FOR_STALL: begin
                // Keep presenting the buffered data until the pipeline moves.
                w_cpu_data = r_rd_buf;
                if (flush_i) begin
                    w_rd_buf_next = 32'h0;
                    w_state_next  = ST_IDLE;
                end else if (!w_stall_any) begin
                    w_state_next  = ST_IDLE;
                end
            end

            default: begin
                w_bus_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase

        // The pipeline must see a quiet interface while reset is held.
        if (rst) begin
            w_stallreq = 1'b0;
            w_cpu_data = 32'h0;
        end
    end

    // State and registered bus/buffer/counter/error update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bus     <= '0;
            r_rd_buf  <= 32'h0;
            r_tmo_cnt <= 16'h0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bus     <= w_bus_next;
            r_rd_buf  <= w_rd_buf_next;
            r_tmo_cnt <= w_tmo_cnt_next;
            r_bus_err <= w_bus_err_next;
        end
    end

    assign wb_adr_o   = r_bus.adr;
    assign wb_dat_o   = r_bus.dat;
    assign wb_sel_o   = r_bus.sel;
    assign wb_we_o    = r_bus.we;
    assign wb_cyc_o   = r_bus.cyc;
    assign wb_stb_o   = r_bus.stb;
    assign bus_err_o  = r_bus_err;
    assign stallreq_o = w_stallreq;
    assign cpu_data_o = w_cpu_data;

endmodule

// File: tb/tb_data_bus_if.sv
// Testbench for data_bus_if: directed vector table, randomized transactions
// against a transaction-level outcome model, and hand-written reset/flush sequences.
module tb_data_bus_if;

    localparam int T      = 4;
    localparam int K_NONE = 0;
    localparam int K_FLUSH = 1;
    localparam int K_ACK  = 2;
    localparam int K_TMO  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;
    int txn_id = 0;

    data_bus_if #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;      // wait cycles before ack (ack in BUSY cycle d+1)
        int          s;      // cycles stall_i stays set after the ack cycle
        logic [5:0]  sval;
        int          f;      // flush cycle: 0 = request cycle, <0 = none
        int          exp_k;  // cycle in which the access ends (0 = never started)
        int          exp_kind;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL txn %0d %s: got %h expected %h at %0t", txn_id, name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one access from its event times: earliest event ends it,
    // ties resolved flush > ack > timeout.
    function automatic void model(input int d, input int f, output int k, output int kind);
        int k_ack;
        int k_fl;
        if (f == 0) begin
            k    = 0;
            kind = K_NONE;
        end else begin
            k_ack = d + 1;
            k_fl  = (f > 0) ? f : 1000;
            k = T;
            if (k_ack < k) k = k_ack;
            if (k_fl < k)  k = k_fl;
            if (k == k_fl)       kind = K_FLUSH;
            else if (k == k_ack) kind = K_ACK;
            else                 kind = K_TMO;
        end
    endfunction

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int d, input int s, input logic [5:0] sval, input int f,
                           input int k, input int kind);
        logic [31:0] exp_rd;
        exp_rd = we ? 32'h0 : rdata;
        txn_id++;
        $display("txn %0d: we=%0d addr=%h sel=%b d=%0d s=%0d f=%0d -> end=%0d kind=%0d",
                 txn_id, we, addr, sel, d, s, f, k, kind);
        // request cycle
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
        flush_i = (f == 0); wb_ack_i = 1'b0; wb_dat_i = $urandom; stall_i = 6'd0;
        @(negedge clk);
        chk("req_stallreq", 32'(stallreq_o), 32'(k > 0));
        chk("req_cpu_data", cpu_data_o, 32'h0);
        chk("req_cyc", 32'(wb_cyc_o), 32'h0);
        step();
        // BUSY cycles; cpu_* are scrambled to show they are not sampled
        for (int j = 1; j <= k; j++) begin
            cpu_ce_i = 1'b1; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom;
            cpu_sel_i = 4'($urandom); cpu_data_i = $urandom;
            flush_i  = (j == f);
            wb_ack_i = (j == d + 1);
            wb_dat_i = (j == d + 1) ? rdata : $urandom;
            if (j == k && kind == K_ACK) stall_i = (s > 0) ? sval : 6'd0;
            else                         stall_i = 6'($urandom);
            @(negedge clk);
            chk("busy_cyc", 32'(wb_cyc_o), 32'h1);
            chk("busy_stb", 32'(wb_stb_o), 32'h1);
            chk("busy_adr", wb_adr_o, addr);
            chk("busy_dat", wb_dat_o, wdata);
            chk("busy_sel", 32'(wb_sel_o), 32'(sel));
            chk("busy_we", 32'(wb_we_o), 32'(we));
            chk("busy_stallreq", 32'(stallreq_o), 32'(j < k));
            chk("busy_cpu_data", cpu_data_o, (j == k && kind == K_ACK) ? exp_rd : 32'h0);
            chk("busy_bus_err", 32'(bus_err_o), 32'h0);
            step();
        end
        // pipeline still frozen after the ack: buffered data held
        if (kind == K_ACK && s > 0) begin
            for (int w = 1; w <= s + 1; w++) begin
                cpu_ce_i = 1'b1; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom;
                cpu_sel_i = 4'($urandom); cpu_data_i = $urandom;
                flush_i = 1'b0; wb_ack_i = 1'($urandom); wb_dat_i = $urandom;
                stall_i = (w <= s) ? sval : 6'd0;
                @(negedge clk);
                chk("wait_cyc", 32'(wb_cyc_o), 32'h0);
                chk("wait_adr", wb_adr_o, 32'h0);
                chk("wait_stallreq", 32'(stallreq_o), 32'h0);
                chk("wait_cpu_data", cpu_data_o, exp_rd);
                chk("wait_bus_err", 32'(bus_err_o), 32'h0);
                step();
            end
        end
        // first idle cycle: bus released, error pulse only after a timeout,
        // a late ack after a flush is ignored
        cpu_ce_i = 1'b0; flush_i = 1'b0; wb_ack_i = (kind == K_FLUSH);
        wb_dat_i = $urandom; stall_i = 6'd0;
        @(negedge clk);
        chk("tail_cyc", 32'(wb_cyc_o), 32'h0);
        chk("tail_stb", 32'(wb_stb_o), 32'h0);
        chk("tail_we", 32'(wb_we_o), 32'h0);
        chk("tail_adr", wb_adr_o, 32'h0);
        chk("tail_dat", wb_dat_o, 32'h0);
        chk("tail_sel", 32'(wb_sel_o), 32'h0);
        chk("tail_stallreq", 32'(stallreq_o), 32'h0);
        chk("tail_cpu_data", cpu_data_o, 32'h0);
        chk("tail_bus_err", 32'(bus_err_o), 32'(kind == K_TMO));
        step();
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("tail2_bus_err", 32'(bus_err_o), 32'h0);
        chk("tail2_cyc", 32'(wb_cyc_o), 32'h0);
        chk("tail2_stallreq", 32'(stallreq_o), 32'h0);
        step();
    endtask

    initial begin
        int d, s, f, k, kind;
        logic we;
        logic [31:0] addr, wdata, rdata;
        logic [3:0] sel;
        logic [5:0] sval;

        vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 2,  0, 6'd0,       -1, 3, K_ACK};
        vecs[1] = '{1'b1, 32'h0000_0013, 4'h1, 32'h5A5A_5A5A, 32'h1111_2222, 0,  0, 6'd0,       -1, 1, K_ACK};
        vecs[2] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h1234_5678, 1,  4, 6'b000011,  -1, 2, K_ACK};
        vecs[3] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         32'hAAAA_5555, 15, 0, 6'd0,        2, 2, K_FLUSH};
        vecs[4] = '{1'b0, 32'h0000_0028, 4'hF, 32'h0,         32'h0,         15, 0, 6'd0,       -1, 4, K_TMO};
        vecs[5] = '{1'b0, 32'h0000_002C, 4'hF, 32'h0,         32'h0,         0,  0, 6'd0,        0, 0, K_NONE};
        vecs[6] = '{1'b0, 32'h0000_0030, 4'h3, 32'h0,         32'hCAFE_BABE, 0,  0, 6'd0,        1, 1, K_FLUSH};
        vecs[7] = '{1'b0, 32'h0000_0034, 4'hC, 32'h0,         32'h8765_4321, 3,  0, 6'd0,       -1, 4, K_ACK};
        vecs[8] = '{1'b1, 32'h0000_0038, 4'hF, 32'hFFFF_0000, 32'h1357_2468, 2,  2, 6'b010000, -1, 3, K_ACK};

        // reset with a live request and ack present: interface must stay quiet
        rst = 1'b1; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
        cpu_addr_i = 32'h100; cpu_sel_i = 4'hF; cpu_data_i = 32'h0;
        wb_dat_i = 32'hFFFF_FFFF; wb_ack_i = 1'b1;
        step();
        @(negedge clk);
        chk("rst_stallreq", 32'(stallreq_o), 32'h0);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("rst_stb", 32'(wb_stb_o), 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'h0);
        step();
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        chk("idle_stallreq", 32'(stallreq_o), 32'h0);
        chk("idle_cyc", 32'(wb_cyc_o), 32'h0);
        step();

        // directed vectors
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].d, vecs[i].s, vecs[i].sval, vecs[i].f, vecs[i].exp_k, vecs[i].exp_kind);
        end

        // randomized transactions against the outcome model
        for (int n = 0; n < 120; n++) begin
            we    = 1'($urandom);
            addr  = $urandom & 32'hFFFF_FFFC;
            sel   = 4'(1 + $urandom % 15);
            wdata = $urandom;
            rdata = $urandom;
            d     = int'($urandom % 6);
            s     = int'($urandom % 4);
            sval  = 6'(1 + $urandom % 63);
            f     = ($urandom % 4 == 0) ? int'($urandom % 5) : -1;
            model(d, f, k, kind);
            run_txn(we, addr, sel, wdata, rdata, d, s, sval, f, k, kind);
        end

        // reset asserted in the middle of BUSY
        txn_id++;
        $display("txn %0d: reset during BUSY", txn_id);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_sel_i = 4'hF; cpu_data_i = 32'h0;
        flush_i = 1'b0; wb_ack_i = 1'b0; stall_i = 6'd0;
        @(negedge clk);
        chk("rb_req_stallreq", 32'(stallreq_o), 32'h1);
        step();
        @(negedge clk);
        chk("rb_busy_cyc", 32'(wb_cyc_o), 32'h1);
        step();
        rst = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rb_rst_stallreq", 32'(stallreq_o), 32'h0);
        chk("rb_rst_cpu_data", cpu_data_o, 32'h0);
        step();
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        chk("rb_cyc", 32'(wb_cyc_o), 32'h0);
        chk("rb_stb", 32'(wb_stb_o), 32'h0);
        chk("rb_adr", wb_adr_o, 32'h0);
        chk("rb_sel", 32'(wb_sel_o), 32'h0);
        chk("rb_bus_err", 32'(bus_err_o), 32'h0);
        chk("rb_stallreq", 32'(stallreq_o), 32'h0);
        step();
        @(negedge clk);
        chk("rb_bus_err2", 32'(bus_err_o), 32'h0);
        step();
        run_txn(1'b0, 32'h44, 4'hF, 32'h0, 32'h0F0F_F0F0, 0, 0, 6'd0, -1, 1, K_ACK);

        // flush while waiting for the pipeline: back to IDLE at once
        txn_id++;
        $display("txn %0d: flush in WAIT_FOR_STALL", txn_id);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80; cpu_sel_i = 4'hF;
        flush_i = 1'b0; wb_ack_i = 1'b0; stall_i = 6'd0;
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_C0DE; stall_i = 6'b100000;
        @(negedge clk);
        chk("fw_ack_cpu_data", cpu_data_o, 32'h0BAD_C0DE);
        chk("fw_ack_stallreq", 32'(stallreq_o), 32'h0);
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0; flush_i = 1'b1;
        @(negedge clk);
        chk("fw_wait_cpu_data", cpu_data_o, 32'h0BAD_C0DE);
        chk("fw_wait_stallreq", 32'(stallreq_o), 32'h0);
        chk("fw_wait_cyc", 32'(wb_cyc_o), 32'h0);
        step();
        flush_i = 1'b0; cpu_we_i = 1'b1; cpu_addr_i = 32'h84; cpu_data_i = 32'h7777_8888;
        @(negedge clk);
        chk("fw_idle_stallreq", 32'(stallreq_o), 32'h1);
        chk("fw_idle_cpu_data", cpu_data_o, 32'h0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA; stall_i = 6'd0;
        @(negedge clk);
        chk("fw_busy_cyc", 32'(wb_cyc_o), 32'h1);
        chk("fw_busy_adr", wb_adr_o, 32'h84);
        chk("fw_busy_we", 32'(wb_we_o), 32'h1);
        chk("fw_busy_cpu_data", cpu_data_o, 32'h0);
        step();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        chk("fw_tail_cyc", 32'(wb_cyc_o), 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
